// File: rtl/frame_sequencer.sv
`default_nettype none
// ============================================================================
// frame_sequencer : zero-padded frame sequencing with line-buffer credit flow
// Revision 1.0
// ============================================================================
module frame_sequencer #(
  parameter int IMG_WIDTH   = 512,
  parameter int IMG_HEIGHT  = 512,
  parameter int NUM_LINEBUF = 4
) (
  input  logic       axi_clk,
  input  logic       axi_reset_n,
  input  logic       i_start,
  output logic       o_busy,
  input  logic       i_data_valid,
  input  logic [7:0] i_data,
  output logic       o_data_ready,
  output logic [7:0] o_pixel_data,
  output logic       o_pixel_data_valid,
  input  logic       i_line_free,
  input  logic       i_result_valid,
  output logic       o_frame_done,
  output logic       o_err
);

  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT + 1);
  localparam int CNT_W = $clog2(IMG_WIDTH * IMG_HEIGHT + 1);
  localparam int CRD_W = $clog2(NUM_LINEBUF + 1);

  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [CNT_W-1:0] RES_TOTAL = CNT_W'(IMG_WIDTH * IMG_HEIGHT);
  localparam logic [CRD_W-1:0] CRD_MAX   = CRD_W'(NUM_LINEBUF);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PAD_TOP = 3'd1,
    S_PASS    = 3'd2,
    S_PAD_BOT = 3'd3,
    S_DRAIN   = 3'd4
  } state_t;

  state_t           state, state_nx;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [CNT_W-1:0] res_cnt;
  logic [CRD_W-1:0] credits;

  logic pad_emit, pass_xfer, start_acc, done_fire;
  logic advance, row_start, col_wrap;

  assign o_busy    = (state != S_IDLE);
  assign advance   = pad_emit | pass_xfer;
  assign row_start = advance && (col == '0);
  assign col_wrap  = advance && (col == COL_LAST);

  always_comb begin
    state_nx     = state;
    o_data_ready = 1'b0;
    pad_emit     = 1'b0;
    pass_xfer    = 1'b0;
    start_acc    = 1'b0;
    done_fire    = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_start) begin
          start_acc = 1'b1;
          state_nx  = S_PAD_TOP;
        end
      end
      S_PAD_TOP: begin
        // a started row always completes; only its first pixel needs a credit
        pad_emit = (col != '0) || (credits != '0);
        if (pad_emit && col == COL_LAST) state_nx = S_PASS;
      end
      S_PASS: begin
        o_data_ready = (col != '0) || (credits != '0);
        pass_xfer    = i_data_valid && o_data_ready;
        if (pass_xfer && col == COL_LAST && row == ROW_LAST) state_nx = S_PAD_BOT;
      end
      S_PAD_BOT: begin
        pad_emit = (col != '0) || (credits != '0);
        if (pad_emit && col == COL_LAST) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        if (res_cnt == RES_TOTAL) begin
          done_fire = 1'b1;
          state_nx  = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) state <= S_IDLE;
    else              state <= state_nx;
  end

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      col                <= '0;
      row                <= '0;
      res_cnt            <= '0;
      credits            <= CRD_MAX;
      o_err              <= 1'b0;
      o_pixel_data       <= 8'h00;
      o_pixel_data_valid <= 1'b0;
      o_frame_done       <= 1'b0;
    end else begin
      o_pixel_data_valid <= advance;
      o_frame_done       <= done_fire;
      if (advance) o_pixel_data <= pass_xfer ? i_data : 8'h00;

      if (start_acc) begin
        col     <= '0;
        row     <= '0;
        res_cnt <= '0;
      end else begin
        if (advance) col <= col_wrap ? '0 : col + 1'b1;
        if (pass_xfer && col_wrap) row <= row + 1'b1;
        if (state != S_IDLE && i_result_valid) res_cnt <= res_cnt + 1'b1;
      end

      // coincident consume and release cancel out
      if (start_acc) begin
        credits <= CRD_MAX;
      end else if (row_start && !i_line_free) begin
        credits <= credits - 1'b1;
      end else if (i_line_free && !row_start) begin
        if (credits == CRD_MAX) o_err <= 1'b1;
        else                    credits <= credits + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_frame_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// Scoreboard bench for frame_sequencer at 8x4 pixels with 4 line buffers.
module tb_frame_sequencer;
  localparam int W = 8;
  localparam int H = 4;
  localparam int N = 4;

  logic       axi_clk        = 1'b0;
  logic       axi_reset_n    = 1'b0;
  logic       i_start        = 1'b0;
  logic       i_data_valid   = 1'b0;
  logic [7:0] i_data         = 8'h00;
  logic       i_line_free    = 1'b0;
  logic       i_result_valid = 1'b0;
  logic       o_busy, o_data_ready, o_pixel_data_valid, o_frame_done, o_err;
  logic [7:0] o_pixel_data;

  int  errors  = 0;
  int  checks  = 0;
  int  tot_out = 0;
  int  row_out = 0;
  bit  auto_free = 1'b0;
  bit  pend_free = 1'b0;
  logic [7:0] exp_q[$];

  frame_sequencer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .NUM_LINEBUF(N)) dut (
    .axi_clk           (axi_clk),
    .axi_reset_n       (axi_reset_n),
    .i_start           (i_start),
    .o_busy            (o_busy),
    .i_data_valid      (i_data_valid),
    .i_data            (i_data),
    .o_data_ready      (o_data_ready),
    .o_pixel_data      (o_pixel_data),
    .o_pixel_data_valid(o_pixel_data_valid),
    .i_line_free       (i_line_free),
    .i_result_valid    (i_result_valid),
    .o_frame_done      (o_frame_done),
    .o_err             (o_err)
  );

  always #5 axi_clk = ~axi_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge axi_clk);
    #1;
  endtask

  // Monitor: every valid output pixel is popped from the scoreboard.
  initial forever begin
    @(negedge axi_clk);
    if (axi_reset_n && o_pixel_data_valid) begin
      tot_out++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pixel: got %0d expected no output at %0t", o_pixel_data, $time);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        chk("pixel", o_pixel_data, e);
      end
    end
  end

  // Line-free driver: pulses are requested via pend_free, or automatically per emitted row.
  initial forever begin
    @(negedge axi_clk);
    i_line_free = pend_free;
    pend_free   = 1'b0;
    if (auto_free && axi_reset_n && o_pixel_data_valid) begin
      row_out++;
      if (row_out == W) begin
        row_out   = 0;
        pend_free = 1'b1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic push_frame;
    for (int k = 0; k < W; k++) exp_q.push_back(8'h00);
    for (int k = 1; k <= W * H; k++) exp_q.push_back(8'(k));
    for (int k = 0; k < W; k++) exp_q.push_back(8'h00);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"},   o_busy,             0);
    chk({tag, "_ready"},  o_data_ready,       0);
    chk({tag, "_pdata"},  o_pixel_data,       0);
    chk({tag, "_pvalid"}, o_pixel_data_valid, 0);
    chk({tag, "_done"},   o_frame_done,       0);
    chk({tag, "_err"},    o_err,              0);
  endtask

  task automatic start_frame;
    i_start = 1'b1;
    tick;
    i_start = 1'b0;
    chk("busy_after_start", o_busy, 1);
  endtask

  task automatic send_pixels(input int from, input int to, input int restart_at);
    int d;
    int guard;
    d = from;
    guard = 0;
    i_data_valid = 1'b1;
    i_data = 8'(d);
    while (d <= to && guard < 400) begin
      bit x;
      i_start = (d == restart_at);
      x = o_data_ready;
      tick;
      guard++;
      if (x) begin
        d++;
        i_data = 8'(d);
      end
    end
    i_start = 1'b0;
    i_data_valid = 1'b0;
    chk("send_progress", d, to + 1);
  endtask

  task automatic send_gapped(input int from, input int to);
    int d;
    int guard;
    bit phase;
    d = from;
    guard = 0;
    phase = 1'b0;
    while (d <= to && guard < 100) begin
      bit x;
      i_data_valid = phase;
      i_data = 8'(d);
      chk("ready_midrow", o_data_ready, 1);
      x = phase && o_data_ready;
      tick;
      guard++;
      chk("gap_mirror", o_pixel_data_valid, x);
      if (x) d++;
      phase = !phase;
    end
    i_data_valid = 1'b0;
    chk("gapped_progress", d, to + 1);
  endtask

  task automatic finish_frame;
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 300) begin
      tick;
      g++;
    end
    chk("drain_pending", exp_q.size(), 0);
    for (int k = 0; k < W * H; k++) begin
      i_result_valid = 1'b1;
      tick;
    end
    i_result_valid = 1'b0;
    chk("done_not_early", o_frame_done, 0);
    chk("busy_before_done", o_busy, 1);
    tick;
    chk("frame_done", o_frame_done, 1);
    chk("busy_fall", o_busy, 0);
    tick;
    chk("done_one_cycle", o_frame_done, 0);
    chk("err_clear", o_err, 0);
    auto_free = 1'b0;
  endtask

  task automatic run_nominal(input int restart_at);
    tot_out = 0;
    row_out = 0;
    auto_free = 1'b1;
    push_frame();
    start_frame();
    send_pixels(1, W * H, restart_at);
    finish_frame();
  endtask

  initial begin
    axi_reset_n = 1'b0;
    repeat (2) tick;
    check_reset_outputs("por");
    axi_reset_n = 1'b1;
    tick;

    run_nominal(0);
    run_nominal(10);

    // Credit stall at data row 3, then a gapped row started on the last credit.
    tot_out = 0;
    auto_free = 1'b0;
    push_frame();
    start_frame();
    send_pixels(1, 24, 0);
    i_data_valid = 1'b1;
    i_data = 8'd25;
    repeat (3) tick;
    chk("stall_ready", o_data_ready, 0);
    chk("stall_count", tot_out, 32);
    pend_free = 1'b1;
    tick;
    chk("ready_restored", o_data_ready, 1);
    send_gapped(25, 32);
    repeat (4) tick;
    chk("pad_bot_stall", tot_out, 40);
    pend_free = 1'b1;
    finish_frame();

    // Line free coincident with the row-2 start at credits=1.
    tot_out = 0;
    push_frame();
    start_frame();
    send_pixels(1, 16, 0);
    pend_free = 1'b1;
    send_pixels(17, 32, 0);
    repeat (4) tick;
    chk("coinc_pad_stall", tot_out, 40);
    pend_free = 1'b1;
    finish_frame();

    // Reset mid-PASS at data row 2, col 3.
    tot_out = 0;
    row_out = 0;
    auto_free = 1'b1;
    push_frame();
    start_frame();
    send_pixels(1, 19, 0);
    axi_reset_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    exp_q.delete();
    auto_free = 1'b0;
    pend_free = 1'b0;
    i_line_free = 1'b0;
    repeat (3) tick;
    chk("midrst_no_done", o_frame_done, 0);
    axi_reset_n = 1'b1;
    tick;
    run_nominal(0);

    // Credit overflow in IDLE at full credits.
    axi_reset_n = 1'b0;
    tick;
    axi_reset_n = 1'b1;
    tick;
    chk("err_pre", o_err, 0);
    pend_free = 1'b1;
    repeat (2) tick;
    chk("err_overflow", o_err, 1);
    chk("idle_after_overflow", o_busy, 0);
    repeat (3) tick;
    chk("err_sticky", o_err, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/frame_sequencer.md
Name: frame_sequencer

Overview:
- Sits between the slave pixel stream and the 3x3 line-buffer/window controller that feeds the convolution core.
- Sequences one frame: emits a zero top padding row, passes IMG_HEIGHT input rows, then emits a zero bottom padding row. The convolver then returns exactly IMG_WIDTH*IMG_HEIGHT results.
- Line-buffer occupancy is tracked with a credit counter. Input is throttled so a row is started only when a line buffer is free.
- Counts convolved results and raises a one-cycle frame-done interrupt.

Parameters:
- IMG_WIDTH, 512, pixels per row.
- IMG_HEIGHT, 512, input rows per frame (excluding padding).
- NUM_LINEBUF, 4, line buffers in the downstream controller; this is the initial and maximum credit.

Ports:
- axi_clk  input  1  clock.
- axi_reset_n  input  1  reset; asynchronous, active-low.
- i_start  input  1  one-cycle frame start request.
- o_busy  output  1  high while a frame is in progress.
- i_data_valid  input  1  slave pixel valid.
- i_data  input  8  slave pixel.
- o_data_ready  output  1  slave ready.
- o_pixel_data  output  8  pixel to the line-buffer controller.
- o_pixel_data_valid  output  1  pixel valid to the line-buffer controller; the downstream side has no backpressure.
- i_line_free  input  1  one-cycle pulse: downstream released one line buffer.
- i_result_valid  input  1  convolved-pixel valid from the conv core.
- o_frame_done  output  1  one-cycle interrupt after the last result.
- o_err  output  1  sticky credit-overflow flag.

Behaviour:
- Reset values (asynchronous, all outputs):
  - o_busy=0, o_data_ready=0, o_pixel_data=0, o_pixel_data_valid=0, o_frame_done=0, o_err=0.
  - state=IDLE, credits=NUM_LINEBUF, col=0, row=0, result count=0.
- Counters:
  - col: $clog2(IMG_WIDTH) bits.
  - row: $clog2(IMG_HEIGHT+1) bits.
  - result count: $clog2(IMG_WIDTH*IMG_HEIGHT+1) bits.
  - credits: $clog2(NUM_LINEBUF+1) bits.
- Outputs o_pixel_data, o_pixel_data_valid and o_frame_done are registered. Latency from accepted input pixel to o_pixel_data_valid is 1 cycle.
- Credits:
  - A row start (col==0 with a pixel emitted or accepted) consumes 1 credit.
  - i_line_free adds 1 credit.
  - A row start and i_line_free in the same cycle leave credits unchanged.
  - i_line_free while credits==NUM_LINEBUF and no row start in that cycle: credits saturate and o_err is set. o_err clears only on reset.
  - credits is reloaded to NUM_LINEBUF on an accepted i_start.
- o_busy = (state != IDLE).
- State machine:
  - IDLE:
    - o_data_ready=0.
    - i_start → PAD_TOP; clear col, row and result count; reload credits.
    - i_result_valid is ignored in IDLE.
  - PAD_TOP:
    - Emits IMG_WIDTH zero pixels, one per cycle, starting only when credits>0.
    - Once the row starts it runs to completion regardless of credits.
    - col wraps at IMG_WIDTH-1 → PASS.
  - PASS:
    - o_data_ready = (col!=0) || (credits>0). Mid-row, ready stays high even when credits==0.
    - A transfer occurs on i_data_valid && o_data_ready; the next cycle shows o_pixel_data=i_data and o_pixel_data_valid=1.
    - Input gaps produce o_pixel_data_valid=0 cycles; there is no padding or bubble insertion mid-row.
    - col wrap increments row. Completing row IMG_HEIGHT-1 → PAD_BOT.
  - PAD_BOT:
    - o_data_ready=0.
    - Same rules as PAD_TOP; completion → DRAIN.
  - DRAIN:
    - o_data_ready=0.
    - Waits for result count == IMG_WIDTH*IMG_HEIGHT.
  - Result counting:
    - i_result_valid increments the result count in every non-IDLE state.
    - The cycle after the count reaches IMG_WIDTH*IMG_HEIGHT: o_frame_done=1 for exactly 1 cycle and state → IDLE.
    - If the final count is reached before DRAIN (not legal upstream), the done pulse is deferred until DRAIN is entered.
- i_start while busy is ignored (no restart, no counter change).
- Reset mid-frame returns immediately to the reset values. A partial row is abandoned and no o_frame_done is produced.
- Pixel data is never modified; padding pixels are 8'h00.

Test Plan:
- All scenarios use IMG_WIDTH=8, IMG_HEIGHT=4, NUM_LINEBUF=4.
- Nominal frame:
  - Stimulus: i_start; continuous i_data 1..32; i_line_free pulsed after each emitted row; 32 i_result_valid pulses.
  - Response: 48 valid outputs (8 zeros, 1..32 in order, 8 zeros); o_frame_done high exactly 1 cycle after the 32nd result; o_busy falls the same cycle; o_err=0.
- Credit stall:
  - Stimulus: no i_line_free; continuous input.
  - Response: PAD_TOP plus 3 data rows emitted (32 valid); o_data_ready=0 at col 0 of data row 3. A single i_line_free restores ready next cycle and the row completes.
- Mid-row credit exhaustion with gaps:
  - Stimulus: credits hit 0 at a row start; i_data_valid toggles every other cycle.
  - Response: o_data_ready stays 1 through col 7; output valid gaps mirror input gaps at 1-cycle latency.
- Simultaneous and overflow credit events:
  - i_line_free coincident with a row start at credits=1 → credits stay 1.
  - i_line_free in IDLE at credits=4 → o_err=1, credits=4.
- Start while busy: second i_start mid-PASS is ignored; output sequence identical to the nominal frame.
- Reset mid-PASS:
  - Stimulus: assert axi_reset_n=0 at data row 2, col 3.
  - Response: all outputs at reset values asynchronously; no o_frame_done. After release, a fresh i_start runs a full nominal frame.
